// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - LC-3 core to memory responder request/response bundle
interface lc3_mem_responder_if;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   // Core side drives the request, responder side answers it
   modport master (
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC-3 memory responder: word RAM, KBSR/KBDR, DSR/DDR, wait-state handshake
module lc3_mem_responder #(
   parameter int DEPTH_W     = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   lc3_mem_responder_if.slave  mem,
   input  logic                kb_valid,
   input  logic [7:0]          kb_data,
   output logic                disp_valid,
   output logic [7:0]          disp_data,
   input  logic                disp_ready
);

   localparam int          RAM_WORDS = 1 << DEPTH_W;
   localparam logic [15:0] IO_BASE   = 16'hFE00;
   localparam logic [15:0] KBSR      = 16'hFE00;
   localparam logic [15:0] KBDR      = 16'hFE02;
   localparam logic [15:0] DSR       = 16'hFE04;
   localparam logic [15:0] DDR       = 16'hFE06;
   localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic        ready_q;

   logic        kb_full_q, kb_full_d;
   logic [7:0]  kb_reg_q, kb_reg_d;
   logic        disp_valid_q, disp_valid_d;
   logic [7:0]  disp_data_q, disp_data_d;

   logic [15:0] ram [RAM_WORDS];

   logic        enter_resp;
   logic [15:0] rd_addr;
   logic        rd_we;
   logic [15:0] rd_data;
   logic        kbdr_rd_done;
   logic        ddr_wr_done;
   logic        ram_wr;

   // With zero wait states the access goes IDLE->RESP before addr_q is latched,
   // so the read mux must look at the live bus in that case
   always_comb begin
      rd_addr    = (state_q == ST_IDLE) ? mem.mem_addr : addr_q;
      rd_we      = (state_q == ST_IDLE) ? mem.mem_we   : we_q;
      enter_resp = ((state_q == ST_IDLE) && mem.mem_en && ZERO_WAIT) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd0));
   end

   // Read data selection across RAM and the memory-mapped device registers
   always_comb begin
      rd_data = 16'h0000;
      if (rd_addr < IO_BASE) begin
         rd_data = ram[rd_addr[DEPTH_W-1:0]];
      end else begin
         case (rd_addr)
            KBSR:    rd_data = {kb_full_q, 15'b0};
            KBDR:    rd_data = {8'h00, kb_reg_q};
            DSR:     rd_data = {~disp_valid_q, 15'b0};
            DDR:     rd_data = {8'h00, disp_data_q};
            default: rd_data = 16'h0000;
         endcase
      end
   end

   // Side effects of an access all land on the edge that ends the RESP cycle
   always_comb begin
      kbdr_rd_done = (state_q == ST_RESP) && !we_q && (addr_q == KBDR);
      ddr_wr_done  = (state_q == ST_RESP) &&  we_q && (addr_q == DDR);
      ram_wr       = (state_q == ST_RESP) &&  we_q && (addr_q < IO_BASE);
   end

   // Access sequencer: capture request, count wait states, strobe ready and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (enter_resp) begin
            ready_q <= 1'b1;
            if (!rd_we) begin
               rdata_q <= rd_data;
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (mem.mem_en) begin
                  we_q    <= mem.mem_we;
                  addr_q  <= mem.mem_addr;
                  wdata_q <= mem.mem_wdata;
                  cnt_q   <= WAIT_LOAD;
                  state_q <= ZERO_WAIT ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Keyboard holding register; a KBDR read that completes alongside a new
   // character hands back the old one and keeps the register full with the new
   always_comb begin
      kb_full_d = kb_full_q;
      kb_reg_d  = kb_reg_q;
      if (kbdr_rd_done) begin
         kb_full_d = kb_valid;
         if (kb_valid) begin
            kb_reg_d = kb_data;
         end
      end else if (kb_valid && !kb_full_q) begin
         kb_full_d = 1'b1;
         kb_reg_d  = kb_data;
      end
   end

   // Display data register; a DDR write wins over a same-cycle consume
   always_comb begin
      disp_valid_d = disp_valid_q;
      disp_data_d  = disp_data_q;
      if (ddr_wr_done) begin
         disp_valid_d = 1'b1;
         disp_data_d  = wdata_q[7:0];
      end else if (disp_valid_q && disp_ready) begin
         disp_valid_d = 1'b0;
      end
   end

   // Device register state
   always_ff @(posedge clk) begin
      if (rst) begin
         kb_full_q    <= 1'b0;
         kb_reg_q     <= 8'h00;
         disp_valid_q <= 1'b0;
         disp_data_q  <= 8'h00;
      end else begin
         kb_full_q    <= kb_full_d;
         kb_reg_q     <= kb_reg_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
      end
   end

   // Word RAM, contents survive reset; a reset landing on RESP blocks the commit
   always_ff @(posedge clk) begin
      if (ram_wr && !rst) begin
         ram[addr_q[DEPTH_W-1:0]] <= wdata_q;
      end
   end

   assign mem.mem_ready = ready_q;
   assign mem.mem_rdata = rdata_q;
   assign disp_valid    = disp_valid_q;
   assign disp_data     = disp_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - self-checking bench for lc3_mem_responder
module tb_lc3_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       kb_valid, kb_valid0;
   logic [7:0] kb_data, kb_data0;
   logic       disp_ready, disp_ready0;
   logic       disp_valid, disp_valid0;
   logic [7:0] disp_data, disp_data0;

   int checks = 0;
   int errors = 0;

   lc3_mem_responder_if m ();
   lc3_mem_responder_if m0 ();

   lc3_mem_responder #(.DEPTH_W(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .mem(m),
      .kb_valid(kb_valid), .kb_data(kb_data),
      .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
   );

   lc3_mem_responder #(.DEPTH_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .mem(m0),
      .kb_valid(kb_valid0), .kb_data(kb_data0),
      .disp_valid(disp_valid0), .disp_data(disp_data0), .disp_ready(disp_ready0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pkv;
      logic [7:0]  pkd;
      logic        pdr;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [15:0] erd;
      logic        edv;
      logic [7:0]  edd;
   } vec_t;

   vec_t tbl [20];

   logic [15:0] mram  [1024];
   bit          known [1024];
   logic        mkf, mdv;
   logic [7:0]  mkr, mdd;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic kbv, input logic [7:0] kbd, input logic drdy);
      @(negedge clk);
      kb_valid = kbv; kb_data = kbd; disp_ready = drdy;
      @(posedge clk); #1;
      kb_valid = 1'b0; disp_ready = 1'b0;
   endtask

   // One access on the WAIT_CYCLES=2 instance; kbv/drdy are driven during the RESP cycle
   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic kbv, input logic [7:0] kbd, input logic drdy,
                         output logic [15:0] rdata, output int lat);
      @(negedge clk);
      m.mem_en = 1'b1; m.mem_we = we; m.mem_addr = addr; m.mem_wdata = wdata;
      lat = -1;
      rdata = 16'h0000;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            m.mem_addr  = ~addr;
            m.mem_wdata = ~wdata;
         end
         if (m.mem_ready) begin
            lat   = k;
            rdata = m.mem_rdata;
            m.mem_en = 1'b0;
            kb_valid = kbv; kb_data = kbd; disp_ready = drdy;
            @(posedge clk); #1;
            kb_valid = 1'b0; disp_ready = 1'b0;
            break;
         end
      end
      m.mem_en = 1'b0;
   endtask

   function automatic logic [15:0] model_read(input logic [15:0] a, output bit ok);
      ok = 1'b1;
      if (a < 16'hFE00) begin
         ok = known[a[9:0]];
         return mram[a[9:0]];
      end
      case (a)
         16'hFE00: return {mkf, 15'b0};
         16'hFE02: return {8'h00, mkr};
         16'hFE04: return {~mdv, 15'b0};
         16'hFE06: return {8'h00, mdd};
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic model_edge(input bit acc, input logic we, input logic [15:0] a, input logic [15:0] wd,
                             input logic kbv, input logic [7:0] kbd, input logic drdy);
      if (acc && !we && a == 16'hFE02) begin
         mkf = kbv;
         if (kbv) mkr = kbd;
      end else if (kbv && !mkf) begin
         mkf = 1'b1;
         mkr = kbd;
      end
      if (acc && we && a == 16'hFE06) begin
         mdv = 1'b1;
         mdd = wd[7:0];
      end else if (mdv && drdy) begin
         mdv = 1'b0;
      end
      if (acc && we && a < 16'hFE00) begin
         mram[a[9:0]]  = wd;
         known[a[9:0]] = 1'b1;
      end
   endtask

   initial begin
      logic [15:0] rd, exp, a, wd, hold;
      logic [15:0] io_addr [7];
      logic        we, kbv, drdy, rkbv, rdrdy;
      logic [7:0]  kbd, rkbd;
      int          lat;
      bit          ok, hold_ok, seen;

      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h0405, 16'hBEEF, 16'h1234, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE10, 16'h0000, 16'h0000, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 8'h41, 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b0, 8'h00};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0, 8'h00};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 8'h00};
      tbl[8]  = '{1'b1, 8'h41, 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b0, 8'h00};
      tbl[9]  = '{1'b1, 8'h42, 1'b0, 1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0, 8'h00};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 8'h00};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFE06, 16'h0058, 16'h0000, 1'b1, 8'h58};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h0000, 1'b1, 8'h58};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE06, 16'h0000, 16'h0058, 1'b1, 8'h58};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0, 8'h58};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFE02, 16'hFFFF, 16'h8000, 1'b0, 8'h58};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFE00, 16'hFFFF, 16'h8000, 1'b0, 8'h58};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 8'h58};
      tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFE10, 16'h1111, 16'h0000, 1'b0, 8'h58};
      tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 8'h58};

      io_addr = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE01, 16'hFE10, 16'hFFFF};

      rst = 1'b1;
      m.mem_en = 1'b0;  m.mem_we = 1'b0;  m.mem_addr = 16'h0;  m.mem_wdata = 16'h0;
      m0.mem_en = 1'b0; m0.mem_we = 1'b0; m0.mem_addr = 16'h0; m0.mem_wdata = 16'h0;
      kb_valid = 1'b0;  kb_data = 8'h00;  disp_ready = 1'b0;
      kb_valid0 = 1'b0; kb_data0 = 8'h00; disp_ready0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready",  {15'b0, m.mem_ready}, 16'h0000);
      chk("reset_rdata",  m.mem_rdata, 16'h0000);
      chk("reset_dvalid", {15'b0, disp_valid}, 16'h0000);
      chk("reset_ddata",  {8'h00, disp_data}, 16'h0000);
      chk("reset0_ready", {15'b0, m0.mem_ready}, 16'h0000);
      rst = 1'b0;

      // Zero wait states, mem_en held: write then continuous reads, ready every other cycle
      @(negedge clk);
      m0.mem_en = 1'b1; m0.mem_we = 1'b1; m0.mem_addr = 16'h0033; m0.mem_wdata = 16'hA5A5;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         chk($sformatf("w0_ready_c%0d", k), {15'b0, m0.mem_ready}, (k % 2 == 1) ? 16'h0001 : 16'h0000);
         if (k == 1) begin
            chk("w0_write_keeps_rdata", m0.mem_rdata, 16'h0000);
            m0.mem_we = 1'b0;
         end
         if (k == 3) chk("w0_read_data", m0.mem_rdata, 16'hA5A5);
      end
      m0.mem_en = 1'b0;

      // Directed table on the two-wait-state instance
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].pkv || tbl[i].pdr) pulse(tbl[i].pkv, tbl[i].pkd, tbl[i].pdr);
         access(tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0, 8'h00, 1'b0, rd, lat);
         chk($sformatf("t%0d_latency", i), 16'(lat), 16'd3);
         chk($sformatf("t%0d_rdata", i), rd, tbl[i].erd);
         chk($sformatf("t%0d_no_double", i), {15'b0, m.mem_ready}, 16'h0000);
         chk($sformatf("t%0d_dvalid", i), {15'b0, disp_valid}, {15'b0, tbl[i].edv});
         chk($sformatf("t%0d_ddata", i), {8'h00, disp_data}, {8'h00, tbl[i].edd});
      end

      // KBDR read completing together with a new keyboard character
      pulse(1'b1, 8'h31, 1'b0);
      access(1'b0, 16'hFE02, 16'h0, 1'b1, 8'h32, 1'b0, rd, lat);
      chk("kb_coinc_old", rd, 16'h0031);
      access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("kb_coinc_full", rd, 16'h8000);
      access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("kb_coinc_new", rd, 16'h0032);
      access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("kb_coinc_empty", rd, 16'h0000);

      // DDR write completing together with a display handshake
      access(1'b1, 16'hFE06, 16'h0061, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("ddr_first_valid", {15'b0, disp_valid}, 16'h0001);
      access(1'b1, 16'hFE06, 16'h0062, 1'b0, 8'h00, 1'b1, rd, lat);
      chk("ddr_coinc_valid", {15'b0, disp_valid}, 16'h0001);
      chk("ddr_coinc_data",  {8'h00, disp_data}, 16'h0062);
      pulse(1'b0, 8'h00, 1'b1);
      chk("ddr_consumed", {15'b0, disp_valid}, 16'h0000);

      // Reset in the middle of a write
      access(1'b1, 16'h0020, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
      access(1'b0, 16'h0010, 16'h0000, 1'b0, 8'h00, 1'b0, rd, lat);
      access(1'b1, 16'hFE06, 16'h0077, 1'b0, 8'h00, 1'b0, rd, lat);
      pulse(1'b1, 8'h55, 1'b0);
      @(negedge clk);
      m.mem_en = 1'b1; m.mem_we = 1'b1; m.mem_addr = 16'h0020; m.mem_wdata = 16'hDEAD;
      @(posedge clk); #1;
      rst = 1'b1;
      m.mem_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_ready",  {15'b0, m.mem_ready}, 16'h0000);
      chk("rst_mid_rdata",  m.mem_rdata, 16'h0000);
      chk("rst_mid_dvalid", {15'b0, disp_valid}, 16'h0000);
      chk("rst_mid_ddata",  {8'h00, disp_data}, 16'h0000);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (m.mem_ready) seen = 1'b1;
      end
      chk("rst_mid_no_ready", {15'b0, seen}, 16'h0000);
      access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("rst_mid_kbsr", rd, 16'h0000);
      access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("rst_mid_kbdr", rd, 16'h0000);
      access(1'b0, 16'h0020, 16'h0, 1'b0, 8'h00, 1'b0, rd, lat);
      chk("rst_mid_no_commit", rd, 16'h0000);

      // Randomized traffic against the reference model
      mkf = 1'b0; mkr = 8'h00; mdv = 1'b0; mdd = 8'h00;
      for (int i = 0; i < 1024; i++) known[i] = 1'b0;
      hold = 16'h0000;
      hold_ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         kbv  = ($urandom_range(0, 3) == 0);
         kbd  = 8'($urandom);
         drdy = ($urandom_range(0, 3) == 0);
         if (kbv || drdy) begin
            pulse(kbv, kbd, drdy);
            model_edge(1'b0, 1'b0, 16'h0, 16'h0, kbv, kbd, drdy);
         end
         if ($urandom_range(0, 1) == 0) a = {6'($urandom_range(0, 62)), 10'($urandom_range(0, 15))};
         else a = io_addr[$urandom_range(0, 6)];
         we    = 1'($urandom);
         wd    = 16'($urandom);
         rkbv  = ($urandom_range(0, 4) == 0);
         rkbd  = 8'($urandom);
         rdrdy = ($urandom_range(0, 4) == 0);
         exp = model_read(a, ok);
         access(we, a, wd, rkbv, rkbd, rdrdy, rd, lat);
         model_edge(1'b1, we, a, wd, rkbv, rkbd, rdrdy);
         chk($sformatf("r%0d_latency", i), 16'(lat), 16'd3);
         if (!we) begin
            hold = exp;
            hold_ok = ok;
         end
         if (hold_ok) chk($sformatf("r%0d_rdata_%h_%s", i, a, we ? "w" : "r"), rd, hold);
         chk($sformatf("r%0d_dvalid", i), {15'b0, disp_valid}, {15'b0, mdv});
         chk($sformatf("r%0d_ddata", i), {8'h00, disp_data}, {8'h00, mdd});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
